// File: rtl/sa_out_packer.sv
// sa_out_packer: collects quantized 8-lane int8 result beats from the quant
// stage into a small skid FIFO and streams them to the MM2S DMA as AXI-stream,
// marking the final beat of each output matrix with tlast.
module sa_out_packer #(
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int DIM_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  cfg_rows,
  input  logic [DIM_W-1:0]  cfg_cols,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_axis_mm2s_tvalid,
  input  logic              m_axis_mm2s_tready,
  output logic [DATA_W-1:0] m_axis_mm2s_tdata,
  output logic              m_axis_mm2s_tlast,
  output logic [DATA_W/8-1:0] m_axis_mm2s_tkeep,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = 2 * DIM_W;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t state, state_nx;

  logic [DIM_W-1:0] rows_q, cols_q;
  logic [CW-1:0]    total, in_cnt, out_cnt;
  logic             last_in, last_out;

  logic [DATA_W:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             full, empty, push, pop;
  logic [DATA_W:0]  head;

  logic             cfg_ok, start_ok, start_bad;

  // Configuration validity and start classification (only meaningful in IDLE).
  assign cfg_ok    = (cfg_rows != '0) && (cfg_cols != '0) && (cfg_cols[2:0] == 3'b000);
  assign start_ok  = (state == IDLE) && start && cfg_ok;
  assign start_bad = (state == IDLE) && start && !cfg_ok;

  // Beat count derived from the latched dimensions; rows * (cols/8) fits in 2*DIM_W bits.
  assign total = {{DIM_W{1'b0}}, rows_q} * {{DIM_W{1'b0}}, 3'b000, cols_q[DIM_W-1:3]};

  assign last_in  = (in_cnt == total - CW'(1));
  assign last_out = (out_cnt == total - CW'(1));

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Input acceptance depends only on registered state, so no path from s_valid to s_ready.
  assign s_ready = (state == RUN) && !full && (in_cnt < total);
  assign push    = s_valid && s_ready;
  assign pop     = m_axis_mm2s_tvalid && m_axis_mm2s_tready;

  assign m_axis_mm2s_tvalid = !empty;
  assign m_axis_mm2s_tdata  = head[DATA_W:1];
  assign m_axis_mm2s_tlast  = !empty && head[0];
  assign m_axis_mm2s_tkeep  = '1;

  assign busy = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state: launch on a valid start, drain once the last input is in,
  // return to IDLE on the handshake of the final output beat.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_ok) state_nx = RUN;
      RUN:     if (push && last_in) state_nx = DRAIN;
      DRAIN:   if (pop && last_out) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Latched configuration and beat counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      rows_q  <= '0;
      cols_q  <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
    end else if (start_ok) begin
      rows_q  <= cfg_rows;
      cols_q  <= cfg_cols;
      in_cnt  <= '0;
      out_cnt <= '0;
    end else begin
      if (push) in_cnt  <= in_cnt + CW'(1);
      if (pop)  out_cnt <= out_cnt + CW'(1);
    end
  end

  // Completion and config-error pulses, each one cycle after its cause.
  always_ff @(posedge clk) begin
    if (rst) begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      done    <= (state == DRAIN) && pop && last_out;
      cfg_err <= start_bad;
    end
  end

  // FIFO pointers and occupancy; no write while full keeps the head stable under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage: {data, last} per entry.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {s_data, last_in};
    end
  end

endmodule
